// File: rtl/stb_drp_ctl_pkg.sv
// Shared bit positions for the AOPT / XANA2 option registers of the stand-by
// analog control block.
package stb_drp_ctl_pkg;

  localparam int AOPT_DNCHK  = 3;
  localparam int XANA2_LFOSC = 7;
  localparam int XANA2_DRP   = 6;
  localparam int XANA2_IMP   = 4;
  localparam int XANA2_STBRP = 3;
  localparam int XANA2_RDENB = 2;

  localparam int REG_W = 8;

endpackage

// File: rtl/stb_drp_ctl_if.sv
// Register-bus and analog-side signals of stb_drp_ctl. The bus side (master)
// drives the write strobes; the block (slave) drives readback and analog enables.
interface stb_drp_ctl_if;
  // Write protocol: a strobe is sampled on each rising clk edge and loads wdat
  // into its register at that edge; there is no ready, every strobe is accepted,
  // and both strobes may be high together (both registers load the same wdat).
  logic       we_aopt;
  logic       we_xana2;
  logic [7:0] wdat;
  logic [7:0] aopt;
  logic [7:0] xana2;
  logic       DNCHK_EN;
  logic       STB_RP;
  logic       RD_ENB;
  logic       DRP_OSC;
  logic       LFOSC_EN;

  modport master (
    output we_aopt, we_xana2, wdat,
    input  aopt, xana2, DNCHK_EN, STB_RP, RD_ENB, DRP_OSC, LFOSC_EN
  );

  modport slave (
    input  we_aopt, we_xana2, wdat,
    output aopt, xana2, DNCHK_EN, STB_RP, RD_ENB, DRP_OSC, LFOSC_EN
  );
endinterface

// File: rtl/stb_drp_ctl_osc_div.sv
// Enable-gated modulo-PERIOD counter with a registered pulse that is high for
// counts [START, START+HIGH). Dropping the enable clears count and pulse.
module stb_drp_ctl_osc_div #(
  parameter int unsigned PERIOD = 96,
  parameter int unsigned HIGH   = 48,
  parameter int unsigned START  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic pulse_o
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW:0] LO = (CW+1)'(START);
  localparam logic [CW:0] HW = (CW+1)'(HIGH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic [CW:0]   cnt_x;

  assign cnt_x = {1'b0, cnt_q};

  // Window test uses modular distance from START so no compare is constant;
  // counts below START wrap to values >= HIGH because START+HIGH <= PERIOD.
  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (en_i) begin
      cnt_d   = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + CW'(1);
      pulse_d = (cnt_x - LO) < HW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stb_drp_ctl.sv
// Stand-by analog control: AOPT/XANA2 option registers plus the DRP toggle and
// impedance-check oscillators that drive STB_RP, RD_ENB and DNCHK_EN.
module stb_drp_ctl
  import stb_drp_ctl_pkg::*;
#(
  parameter int unsigned DRP_HALF   = 48,
  parameter int unsigned IMP_ON     = 24,
  parameter int unsigned IMP_PERIOD = 96
) (
  input  logic         clk,
  input  logic         srstz,
  stb_drp_ctl_if.slave bus
);

  logic [REG_W-1:0] aopt_q, aopt_d;
  logic [REG_W-1:0] xana2_q, xana2_d;
  logic             drp_en, imp_en;
  logic             drp_pulse, imp_pulse;

  always_comb begin
    aopt_d  = aopt_q;
    xana2_d = xana2_q;
    if (bus.we_aopt)  aopt_d  = bus.wdat;
    if (bus.we_xana2) xana2_d = bus.wdat;
  end

  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      aopt_q  <= '0;
      xana2_q <= '0;
    end else begin
      aopt_q  <= aopt_d;
      xana2_q <= xana2_d;
    end
  end

  assign drp_en = xana2_q[XANA2_DRP];
  assign imp_en = xana2_q[XANA2_IMP];

  // START = DRP_HALF-1 makes the first rise land DRP_HALF cycles after the
  // enable bit is loaded, the pulse being registered one cycle behind the count.
  stb_drp_ctl_osc_div #(
    .PERIOD (2 * DRP_HALF),
    .HIGH   (DRP_HALF),
    .START  (DRP_HALF - 1)
  ) u_drp_osc (
    .clk     (clk),
    .rst_n   (srstz),
    .en_i    (drp_en),
    .pulse_o (drp_pulse)
  );

  stb_drp_ctl_osc_div #(
    .PERIOD (IMP_PERIOD),
    .HIGH   (IMP_ON),
    .START  (0)
  ) u_imp_osc (
    .clk     (clk),
    .rst_n   (srstz),
    .en_i    (imp_en),
    .pulse_o (imp_pulse)
  );

  // Mode bits gate the pulses so outputs fall back to static values as soon as
  // a mode bit clears, while the divider flushes its state one cycle later.
  assign bus.aopt     = aopt_q;
  assign bus.xana2    = xana2_q;
  assign bus.LFOSC_EN = xana2_q[XANA2_LFOSC];
  assign bus.DRP_OSC  = drp_en & drp_pulse;
  assign bus.STB_RP   = drp_en ? drp_pulse : xana2_q[XANA2_STBRP];
  assign bus.RD_ENB   = drp_en ? drp_pulse : xana2_q[XANA2_RDENB];
  assign bus.DNCHK_EN = aopt_q[AOPT_DNCHK] | (imp_en & imp_pulse);

endmodule

// File: tb/tb_stb_drp_ctl.sv
// Self-checking bench for stb_drp_ctl: directed pins plus random register traffic
// compared every cycle against a time-based model of the oscillators.
module tb_stb_drp_ctl;

  localparam int DRP_HALF   = 48;
  localparam int IMP_ON     = 24;
  localparam int IMP_PERIOD = 96;
  localparam int W          = 21;

  logic clk;
  logic srstz;
  stb_drp_ctl_if bus();

  stb_drp_ctl #(
    .DRP_HALF   (DRP_HALF),
    .IMP_ON     (IMP_ON),
    .IMP_PERIOD (IMP_PERIOD)
  ) dut (
    .clk   (clk),
    .srstz (srstz),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {bus.aopt, bus.xana2, bus.DNCHK_EN, bus.STB_RP, bus.RD_ENB, bus.DRP_OSC, bus.LFOSC_EN};
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0]     m_aopt, m_xana2;
  int             cyc, drp_t0, imp_t0;
  logic [W-1:0]   exp_q[$];

  // Outputs as a function of elapsed cycles since each mode bit was loaded.
  function automatic logic [W-1:0] model_out();
    logic drp, imp, stb, rd, dn;
    int   e;
    drp = 1'b0;
    imp = 1'b0;
    if (m_xana2[6]) begin
      e   = cyc - drp_t0;
      drp = ((e / DRP_HALF) % 2) == 1;
    end
    if (m_xana2[4]) begin
      e   = cyc - imp_t0;
      imp = (e >= 1) && (((e - 1) % IMP_PERIOD) < IMP_ON);
    end
    stb = m_xana2[6] ? drp : m_xana2[3];
    rd  = m_xana2[6] ? drp : m_xana2[2];
    dn  = m_aopt[3] | imp;
    return {m_aopt, m_xana2, dn, stb, rd, drp, m_xana2[7]};
  endfunction

  always @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      m_aopt  = 8'h00;
      m_xana2 = 8'h00;
      cyc     = 0;
      drp_t0  = 0;
      imp_t0  = 0;
      exp_q.delete();
    end else begin
      logic [7:0] nx;
      cyc++;
      if (bus.we_aopt) m_aopt = bus.wdat;
      if (bus.we_xana2) begin
        nx = bus.wdat;
        if (nx[6] && !m_xana2[6]) drp_t0 = cyc;
        if (nx[4] && !m_xana2[4]) imp_t0 = cyc;
        m_xana2 = nx;
      end
      exp_q.push_back(model_out());
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (srstz && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("cycle_outputs", dut_vec(), e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write(input logic wa, input logic wx, input logic [7:0] d);
    @(negedge clk);
    bus.we_aopt  = wa;
    bus.we_xana2 = wx;
    bus.wdat     = d;
    @(negedge clk);
    bus.we_aopt  = 1'b0;
    bus.we_xana2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Negedges until DRP_OSC reaches level lvl, bounded.
  task automatic wait_drp(input logic lvl, output int n);
    n = 0;
    while (bus.DRP_OSC !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] st_wr [4];
  logic [1:0] st_exp[4];

  initial begin
    int n, hi;
    st_wr[0] = 8'h0C; st_exp[0] = 2'b11;
    st_wr[1] = 8'h04; st_exp[1] = 2'b01;
    st_wr[2] = 8'h08; st_exp[2] = 2'b10;
    st_wr[3] = 8'h00; st_exp[3] = 2'b00;

    srstz        = 1'b0;
    bus.we_aopt  = 1'b0;
    bus.we_xana2 = 1'b0;
    bus.wdat     = 8'h00;
    idle(3);
    check("reset_outputs", dut_vec(), '0);
    srstz = 1'b1;
    idle(2);
    check("post_reset_outputs", dut_vec(), '0);

    // AOPT drives DNCHK_EN; STB_RP/RD_ENB untouched.
    write(1'b1, 1'b0, 8'h08);
    check("aopt_dnchk_on", W'({bus.aopt, bus.DNCHK_EN, bus.STB_RP, bus.RD_ENB}), W'({8'h08, 3'b100}));
    write(1'b1, 1'b0, 8'h00);
    check("aopt_dnchk_off", W'({bus.aopt, bus.DNCHK_EN, bus.STB_RP, bus.RD_ENB}), W'({8'h00, 3'b000}));

    for (int i = 0; i < 4; i++) begin
      write(1'b0, 1'b1, st_wr[i]);
      check("static_stb_rd", W'({bus.STB_RP, bus.RD_ENB, bus.DRP_OSC}), W'({st_exp[i], 1'b0}));
    end

    // DRP + IMP running: first rise, half-period, IMP duty.
    write(1'b0, 1'b1, 8'h50);
    wait_drp(1'b1, n);
    check("drp_first_rise", W'(n), W'(DRP_HALF));
    wait_drp(1'b0, n);
    check("drp_high_time", W'(n), W'(DRP_HALF));
    wait_drp(1'b1, n);
    check("drp_low_time", W'(n), W'(DRP_HALF));
    hi = 0;
    for (int i = 0; i < IMP_PERIOD; i++) begin
      @(negedge clk);
      if (bus.DNCHK_EN === 1'b1) hi++;
    end
    check("imp_high_count", W'(hi), W'(IMP_ON));

    // Leaving DRP/IMP mode falls back to static values next cycle.
    idle(7);
    write(1'b0, 1'b1, 8'h0C);
    check("drp_exit_static", W'({bus.DRP_OSC, bus.STB_RP, bus.RD_ENB, bus.DNCHK_EN}), W'(4'b0110));
    write(1'b0, 1'b1, 8'h50);
    wait_drp(1'b1, n);
    check("drp_restart_rise", W'(n), W'(DRP_HALF));

    // Rewriting with oscillator bits unchanged must not restart the phase.
    idle(10);
    write(1'b0, 1'b1, 8'h5C);
    idle(60);

    // Asynchronous reset mid-period.
    @(negedge clk);
    #2 srstz = 1'b0;
    #1 check("async_reset_outputs", W'({bus.DNCHK_EN, bus.STB_RP, bus.RD_ENB, bus.DRP_OSC, bus.LFOSC_EN}), '0);
    idle(2);
    srstz = 1'b1;
    idle(1);
    check("regs_after_reset", W'({bus.aopt, bus.xana2}), '0);

    // Random register traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] d;
      int         op;
      d  = 8'($urandom);
      op = $urandom_range(0, 9);
      if (op < 6)      write(1'b0, 1'b1, d);
      else if (op < 9) write(1'b1, 1'b0, d);
      else             write(1'b1, 1'b1, d);
      idle($urandom_range(0, 140));
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
